// File: rtl/regwb_pkg.sv
// Shared widths and writeback entry type for the register-file writeback path.
package regwb_pkg;

   localparam int unsigned REG_AW   = 5;
   localparam int unsigned REG_DW   = 32;
   localparam int unsigned NUM_REGS = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [REG_DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback source handshakes (ALU, load) and register-file write port.
// PENDING map is present only when REGWB_PENDING_EN is defined.
interface regwb_if;
   import regwb_pkg::*;

   logic              a_valid;
   logic              a_ready;
   logic [REG_AW-1:0] a_rd;
   logic [REG_DW-1:0] a_data;
   logic              m_valid;
   logic              m_ready;
   logic [REG_AW-1:0] m_rd;
   logic [REG_DW-1:0] m_data;
   logic [REG_DW-1:0] pd;
   logic [REG_AW-1:0] rd;
   logic              en;
`ifdef REGWB_PENDING_EN
   logic [NUM_REGS-1:0] pending;
`endif

   modport slave (
      input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
      output a_ready, m_ready, pd, rd, en
`ifdef REGWB_PENDING_EN
      , output pending
`endif
   );

   modport master (
      output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
      input  a_ready, m_ready, pd, rd, en
`ifdef REGWB_PENDING_EN
      , input pending
`endif
   );

endinterface

// File: rtl/regwb_fifo.sv
// DEPTH-entry writeback FIFO: dual push (M slot first, then A), single pop.
// Per-entry rd/valid are exported only when REGWB_PENDING_EN is defined.
module regwb_fifo
   import regwb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_m,
   input  logic              push_a,
   input  wb_entry_t         m_entry,
   input  wb_entry_t         a_entry,
   output wb_entry_t         head_c,
   output logic              pop_c,
   output logic [CW-1:0]     count
`ifdef REGWB_PENDING_EN
   ,
   output logic [REG_AW-1:0] ent_rd [DEPTH],
   output logic [DEPTH-1:0]  ent_valid_c
`endif
);

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] a_idx;

   assign pop_c  = (count != '0);
   assign head_c = mem[rptr];
   // A lands behind M when both push on the same edge.
   assign a_idx  = wptr + PW'(push_m);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + PW'(push_m) + PW'(push_a);
         rptr  <= rptr + PW'(pop_c);
         count <= count + CW'(push_m) + CW'(push_a) - CW'(pop_c);
      end
   end

   always_ff @(posedge clk) begin
      if (push_m) mem[wptr]  <= m_entry;
      if (push_a) mem[a_idx] <= a_entry;
   end

`ifdef REGWB_PENDING_EN
   always_comb begin
      ent_valid_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_rd[i]      = mem[i].rd;
         ent_valid_c[i] = (CW'(PW'(PW'(i) - rptr)) < count);
      end
   end
`endif

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and load writebacks into one register-file write per cycle; drops R0.
// Optional REGWB_PENDING_EN adds the per-register pending-write map.
module regfile_writeback_arbiter
   import regwb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input logic    clk,
   input logic    rst_n,
   regwb_if.slave bus
);

   logic [CW-1:0]     count;
   logic [CW-1:0]     free;
   logic              m_ready_c;
   logic              a_ready_c;
   logic              push_m;
   logic              push_a;
   logic              pop_c;
   wb_entry_t         m_entry;
   wb_entry_t         a_entry;
   wb_entry_t         head_c;
   logic [REG_DW-1:0] pd_q;
   logic [REG_AW-1:0] rd_q;
   logic              en_q;
`ifdef REGWB_PENDING_EN
   logic [REG_AW-1:0]   ent_rd [DEPTH];
   logic [DEPTH-1:0]    ent_valid_c;
   logic [NUM_REGS-1:0] pending_c;
`endif

   // Ready uses registered occupancy only; M is older and has priority.
   assign free      = CW'(DEPTH) - count;
   assign m_ready_c = (free >= CW'(1));
   assign a_ready_c = (free >= CW'(2)) | ((free == CW'(1)) & ~bus.m_valid);

   // R0 writes handshake normally but never occupy a slot.
   assign push_m  = bus.m_valid & m_ready_c & (bus.m_rd != '0);
   assign push_a  = bus.a_valid & a_ready_c & (bus.a_rd != '0);
   assign m_entry = '{rd: bus.m_rd, data: bus.m_data};
   assign a_entry = '{rd: bus.a_rd, data: bus.a_data};

   regwb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_m      (push_m),
      .push_a      (push_a),
      .m_entry     (m_entry),
      .a_entry     (a_entry),
      .head_c      (head_c),
      .pop_c       (pop_c),
      .count       (count)
`ifdef REGWB_PENDING_EN
      ,
      .ent_rd      (ent_rd),
      .ent_valid_c (ent_valid_c)
`endif
   );

   // Write port: pop head when occupied, otherwise hold address/data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pd_q <= '0;
         rd_q <= '0;
         en_q <= 1'b0;
      end else begin
         en_q <= pop_c;
         if (pop_c) begin
            pd_q <= head_c.data;
            rd_q <= head_c.rd;
         end
      end
   end

   assign bus.m_ready = m_ready_c;
   assign bus.a_ready = a_ready_c;
   assign bus.pd      = pd_q;
   assign bus.rd      = rd_q;
   assign bus.en      = en_q;

`ifdef REGWB_PENDING_EN
   // Queued entries plus the write currently on the port.
   always_comb begin
      pending_c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid_c[i]) pending_c[ent_rd[i]] = 1'b1;
      end
      if (en_q) pending_c[rd_q] = 1'b1;
      pending_c[0] = 1'b0;
   end

   assign bus.pending = pending_c;
`endif

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter (directed table, corner sequences, random vs queue model).
module tb_regfile_writeback_arbiter;
   import regwb_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic clk;
   logic rst_n;
   regwb_if bus ();

   regfile_writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a queue of pending writes and the last write-port state.
   wb_entry_t   q[$];
   logic        mod_en;
   logic [4:0]  mod_rd;
   logic [31:0] mod_pd;
   logic        mod_mr, mod_ar;
   logic        obs_mr, obs_ar, obs_en;
   logic [4:0]  obs_rd;
   logic [31:0] obs_pd;

   typedef struct {
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        av;
      logic [4:0]  ard;
      logic [31:0] ad;
      logic        x_mr;
      logic        x_ar;
      logic        x_en;
      logic [4:0]  x_rd;
      logic [31:0] x_pd;
   } vec_t;

   vec_t tbl[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_pending();
      logic [31:0] p = '0;
      foreach (q[i]) p[q[i].rd] = 1'b1;
      if (mod_en) p[mod_rd] = 1'b1;
      p[0] = 1'b0;
      return p;
   endfunction

   task automatic model_reset();
      q.delete();
      mod_en = 1'b0;
      mod_rd = '0;
      mod_pd = '0;
   endtask

   // One cycle: drive at negedge, sample ready, take edge, update model, sample port.
   task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic av, input logic [4:0] ard, input logic [31:0] ad);
      int free;
      wb_entry_t e;
      @(negedge clk);
      bus.m_valid = mv; bus.m_rd = mrd; bus.m_data = md;
      bus.a_valid = av; bus.a_rd = ard; bus.a_data = ad;
      #1;
      obs_mr = bus.m_ready;
      obs_ar = bus.a_ready;
      free   = int'(DEPTH) - q.size();
      mod_mr = (free >= 1);
      mod_ar = (free >= 2) || (free == 1 && !mv);
      @(posedge clk);
      if (q.size() > 0) begin
         e = q.pop_front();
         mod_en = 1'b1; mod_rd = e.rd; mod_pd = e.data;
      end else begin
         mod_en = 1'b0;
      end
      if (mv && mod_mr && mrd != 0) q.push_back('{rd: mrd, data: md});
      if (av && mod_ar && ard != 0) q.push_back('{rd: ard, data: ad});
      #1;
      obs_en = bus.en;
      obs_rd = bus.rd;
      obs_pd = bus.pd;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".m_ready"}, 64'(obs_mr), 64'(mod_mr));
      chk({tag, ".a_ready"}, 64'(obs_ar), 64'(mod_ar));
      chk({tag, ".en"},      64'(obs_en), 64'(mod_en));
      if (mod_en) begin
         chk({tag, ".rd"}, 64'(obs_rd), 64'(mod_rd));
         chk({tag, ".pd"}, 64'(obs_pd), 64'(mod_pd));
      end
`ifdef REGWB_PENDING_EN
      chk({tag, ".pending"}, 64'(bus.pending), 64'(model_pending()));
`endif
   endtask

   initial begin
      logic        m_hold, a_hold;
      logic        cmv, cav;
      logic [4:0]  cmrd, card;
      logic [31:0] cmd, cad;
      int          seen[$];
      int          nxt;
      logic        adv;

      // Reset held with both sources asserting valid.
      rst_n = 1'b0;
      bus.m_valid = 1'b1; bus.m_rd = 5'd7; bus.m_data = 32'h1234;
      bus.a_valid = 1'b1; bus.a_rd = 5'd8; bus.a_data = 32'h5678;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst.en", 64'(bus.en), 64'd0);
      chk("rst.pd", 64'(bus.pd), 64'd0);
      chk("rst.rd", 64'(bus.rd), 64'd0);
      chk("rst.m_ready", 64'(bus.m_ready), 64'd1);
      chk("rst.a_ready", 64'(bus.a_ready), 64'd1);
      @(negedge clk);
      bus.m_valid = 1'b0; bus.a_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) begin
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         chk("post_rst.en", 64'(obs_en), 64'd0);
      end

      // Directed vectors: single write, same-edge M+A ordering, R0 filter.
      tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0};
      tbl[1] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
      tbl[2] = '{1'b1, 5'd3, 32'd1, 1'b1, 5'd3, 32'd2, 1'b1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF};
      tbl[3] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd1};
      tbl[4] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'd2};
      tbl[5] = '{1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 5'd3, 32'd2};
      tbl[6] = '{1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 5'd3, 32'd2};
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].mv, tbl[i].mrd, tbl[i].md, tbl[i].av, tbl[i].ard, tbl[i].ad);
         chk($sformatf("vec%0d.m_ready", i), 64'(obs_mr), 64'(tbl[i].x_mr));
         chk($sformatf("vec%0d.a_ready", i), 64'(obs_ar), 64'(tbl[i].x_ar));
         chk($sformatf("vec%0d.en", i),      64'(obs_en), 64'(tbl[i].x_en));
         chk($sformatf("vec%0d.rd", i),      64'(obs_rd), 64'(tbl[i].x_rd));
         chk($sformatf("vec%0d.pd", i),      64'(obs_pd), 64'(tbl[i].x_pd));
      end

      // A streams RD=1..9 while draining; every write must retire once, in order.
      nxt = 1;
      for (int cyc = 0; cyc < 60 && seen.size() < 9; cyc++) begin
         step(1'b0, 5'd0, 32'd0, (nxt <= 9), 5'(nxt), 32'(nxt * 16));
         adv = (nxt <= 9) && obs_ar;
         chk_model("fill");
         if (obs_en) seen.push_back(int'(obs_rd));
         if (adv) nxt++;
      end
      chk("fill.count", 64'(seen.size()), 64'd9);
      foreach (seen[i]) chk($sformatf("fill.order%0d", i), 64'(seen[i]), 64'(i + 1));

      // Random traffic; sources hold payload while stalled.
      m_hold = 1'b0; a_hold = 1'b0;
      cmv = 1'b0; cav = 1'b0; cmrd = '0; card = '0; cmd = '0; cad = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!m_hold) begin
            cmv  = ($urandom_range(0, 3) != 0);
            cmrd = 5'($urandom_range(0, 7));
            cmd  = $urandom;
         end
         if (!a_hold) begin
            cav  = ($urandom_range(0, 3) != 0);
            card = 5'($urandom_range(0, 7));
            cad  = $urandom;
         end
         step(cmv, cmrd, cmd, cav, card, cad);
         chk_model("rand");
         m_hold = cmv && !mod_mr;
         a_hold = cav && !mod_ar;
      end
      repeat (6) begin
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         chk_model("flush");
      end

      // Async reset mid-drain with three writes queued.
      step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1);
      step(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3);
      chk("mid.queued", 64'(q.size()), 64'd3);
      @(negedge clk);
      bus.m_valid = 1'b0; bus.a_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst.en", 64'(bus.en), 64'd0);
      chk("mid_rst.rd", 64'(bus.rd), 64'd0);
      chk("mid_rst.pd", 64'(bus.pd), 64'd0);
`ifdef REGWB_PENDING_EN
      chk("mid_rst.pending", 64'(bus.pending), 64'd0);
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         chk("mid_rst.after_en", 64'(obs_en), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
